// File: rtl/steer_scheduler_if.sv
// ---------------------------------------------------------------------------
// steer_scheduler_if -- register bus between a host and steer_scheduler.
//
// Signals:
//   opCode      [1:0]  register select: 00 none, 01 dx, 10 dy, 11 status/control
//   writeEnable        a write to the selected register in this cycle
//   data        [31:0] write data
//   delta       [31:0] combinational read data for the selected register
//
// Modports:
//   master  host side (drives opCode/writeEnable/data, reads delta)
//   slave   scheduler side
// ---------------------------------------------------------------------------
interface steer_scheduler_if;
  logic [1:0]  opCode;
  logic        writeEnable;
  logic [31:0] data;
  logic [31:0] delta;

  modport master (output opCode, output writeEnable, output data, input delta);
  modport slave  (input opCode, input writeEnable, input data, output delta);
endinterface

// File: rtl/steer_scheduler.sv
// ---------------------------------------------------------------------------
// steer_scheduler -- turns debounced left/right button presses into queued
// 90-degree turns that are applied one per game tick, and exposes the
// resulting heading as a (dx, dy) step vector on a small register bus.
//
// Parameters:
//   TICK_DIV    clock cycles per game tick (>= 2)
//   DEB_CYCLES  consecutive stable cycles that qualify a button change
//
// Ports:
//   CLK          system clock, all state on its rising edge
//   RST_N        asynchronous active-low reset
//   leftButton   raw asynchronous button, active-high
//   rightButton  raw asynchronous button, active-high
//   bus          steer_scheduler_if.slave register bus
//
// Build option:
//   STEER_DEBOUNCE_EN  when defined, each synchronized button must hold a new
//                      level for DEB_CYCLES cycles before it is accepted;
//                      when undefined the synchronized level is used directly.
//
// Status register (opCode 11) read layout:
//   {24'b0, valid, dir[1:0], pause, overflow, count[2:0]}
// Control register (opCode 11) write layout:
//   bit0 pause, bit1 flush queue, bit2 clear overflow
// ---------------------------------------------------------------------------
module steer_scheduler #(
  parameter int TICK_DIV   = 8388608,
  parameter int DEB_CYCLES = 65536
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               leftButton,
  input  logic               rightButton,
  steer_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_DX   = 2'b01,
    OP_DY   = 2'b10,
    OP_CTL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  localparam int              TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

  // Index 0 is the left button, index 1 the right button throughout.
  logic [1:0] btn_raw;
  logic [1:0] sync1, sync2;
  logic [1:0] deb_level;
  logic [1:0] deb_prev;
  logic [1:0] rise;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  dir_e       dir, dir_next;
  logic       valid, valid_next;
  logic       pause;
  logic       overflow;

  // Turn queue: one bit per entry, 0 = left turn, 1 = right turn.
  logic [3:0] fifo_mem;
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  logic        wr_any, wr_dx, wr_dy, wr_ctl;
  logic        data_pos, data_neg, data_zero;
  logic        axis_ok, flush;
  logic        full, empty;
  logic        pop, push_req, push;
  logic        ov_set, ov_clr;
  logic [31:0] dx, dy, status;

  assign btn_raw = {rightButton, leftButton};

  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers sample the same pre-edge values regardless of process order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef STEER_DEBOUNCE_EN
  localparam int            DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt [2];

  // The counter only advances while the synchronized level disagrees with the
  // accepted level; a single agreeing cycle (a glitch ending) restarts it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_level  <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_level[i] <= sync2[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end
`else
  assign deb_level = sync2;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_prev <= '0;
    end else begin
      deb_prev <= deb_level;
    end
  end

  assign rise = deb_level & ~deb_prev;

  // Free-running tick divider; writes and pause never touch it.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

  // NOTE: each always_comb assigns a default to every output first, so no
  // path through the block can leave a signal unassigned and infer a latch.
  always_comb begin
    wr_any    = bus.writeEnable && (bus.opCode != OP_NONE);
    wr_dx     = bus.writeEnable && (bus.opCode == OP_DX);
    wr_dy     = bus.writeEnable && (bus.opCode == OP_DY);
    wr_ctl    = bus.writeEnable && (bus.opCode == OP_CTL);
    data_pos  = (bus.data == 32'h0000_0001);
    data_neg  = (bus.data == 32'hFFFF_FFFF);
    data_zero = (bus.data == 32'h0000_0000);
    // Axis writes with any other value are ignored entirely, including the flush.
    axis_ok   = (wr_dx || wr_dy) && (data_pos || data_neg || data_zero);
    flush     = axis_ok || (wr_ctl && bus.data[1]);

    full      = (count == 3'd4);
    empty     = (count == 3'd0);

    // A bus write on the tick cycle takes priority and the pop is skipped.
    pop       = tick && !empty && !pause && !wr_any;
    // Simultaneous left and right presses cancel each other.
    push_req  = rise[0] ^ rise[1];
    // A flush swallows a coincident push silently; a full queue only accepts
    // when a pop frees a slot in the same cycle.
    push      = push_req && !flush && (!full || pop);
    ov_set    = push_req && !flush && full && !pop;
    ov_clr    = wr_ctl && bus.data[2];
  end

  always_comb begin
    dir_next   = dir;
    valid_next = valid;
    if (axis_ok) begin
      if (data_zero) begin
        valid_next = 1'b0;
      end else begin
        valid_next = 1'b1;
        if (wr_dx) dir_next = data_pos ? DIR_RIGHT : DIR_LEFT;
        else       dir_next = data_pos ? DIR_DOWN  : DIR_UP;
      end
    end else if (pop && valid) begin
      // With valid clear the popped entry is simply discarded.
      dir_next = fifo_mem[rd_ptr] ? dir_e'(dir + 2'd1) : dir_e'(dir - 2'd1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dir      <= DIR_RIGHT;
      valid    <= 1'b0;
      pause    <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      dir      <= dir_next;
      valid    <= valid_next;
      if (wr_ctl) pause <= bus.data[0];
      // A new overflow in the same cycle as a clear request leaves it set.
      overflow <= ov_set || (overflow && !ov_clr);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)  rd_ptr <= rd_ptr + 2'd1;
        count <= count + {2'b00, push} - {2'b00, pop};
      end
    end
  end

  // NOTE: queue storage has no reset; count and the pointers define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= rise[1];
  end

  always_comb begin
    dx = '0;
    dy = '0;
    if (valid) begin
      unique case (dir)
        DIR_RIGHT: dx = 32'h0000_0001;
        DIR_DOWN:  dy = 32'h0000_0001;
        DIR_LEFT:  dx = 32'hFFFF_FFFF;
        DIR_UP:    dy = 32'hFFFF_FFFF;
        default:   ;
      endcase
    end
    status = {24'b0, valid, dir, pause, overflow, count};

    bus.delta = '0;
    unique case (bus.opCode)
      OP_DX:   bus.delta = dx;
      OP_DY:   bus.delta = dy;
      OP_CTL:  bus.delta = status;
      default: bus.delta = '0;
    endcase
  end

endmodule

// File: tb/tb_steer_scheduler.sv
// ---------------------------------------------------------------------------
// tb_steer_scheduler -- directed self-checking bench for steer_scheduler with
// TICK_DIV=16 and DEB_CYCLES=4. All stimulus is driven and all outputs are
// sampled on falling clock edges; rising edges are counted here so every
// tick boundary can be targeted exactly.
// Status byte: {valid, dir[1:0], pause, overflow, count[2:0]}.
// ---------------------------------------------------------------------------
module tb_steer_scheduler;

  localparam int TICK = 16;
  localparam int DEB  = 4;

  logic CLK;
  logic RST_N;
  logic leftButton;
  logic rightButton;

  steer_scheduler_if bus ();

  steer_scheduler #(
    .TICK_DIV   (TICK),
    .DEB_CYCLES (DEB)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .leftButton  (leftButton),
    .rightButton (rightButton),
    .bus         (bus)
  );

  int checks   = 0;
  int failures = 0;
  int edges;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Rising edges since reset release; a pop can happen only on edges that are
  // a non-zero multiple of TICK.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) edges <= 0;
    else        edges <= edges + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] op, input logic [31:0] exp);
    logic [31:0] v;
    bus.opCode = op;
    #1;
    v = bus.delta;
    check(tag, v, exp);
  endtask

  // Called on a falling edge: the write lands on the next rising edge.
  task automatic bus_write(input logic [1:0] op, input logic [31:0] d);
    bus.opCode      = op;
    bus.data        = d;
    bus.writeEnable = 1'b1;
    @(negedge CLK);
    bus.writeEnable = 1'b0;
    bus.opCode      = 2'b00;
    bus.data        = '0;
  endtask

  task automatic press(input logic is_right, input int hold);
    if (is_right) rightButton = 1'b1;
    else          leftButton  = 1'b1;
    repeat (hold) @(negedge CLK);
    rightButton = 1'b0;
    leftButton  = 1'b0;
    repeat (10) @(negedge CLK);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while ((edges % TICK) != p && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if ((edges % TICK) != p) begin
      checks++;
      failures++;
      $display("FAIL phase_timeout observed=%0d expected=%0d", edges % TICK, p);
    end
  endtask

  // Advance to the falling edge right after the next tick edge.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((edges % TICK) != 0 && n < 40);
    if ((edges % TICK) != 0) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout observed=%0d expected=0", edges % TICK);
    end
  endtask

  initial begin
    RST_N           = 1'b1;
    leftButton      = 1'b0;
    rightButton     = 1'b0;
    bus.opCode      = 2'b00;
    bus.writeEnable = 1'b0;
    bus.data        = '0;

    // Reset: every register reads zero during and right after reset.
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_reg("rst_op00", 2'b00, 32'h0);
    check_reg("rst_dx",   2'b01, 32'h0);
    check_reg("rst_dy",   2'b10, 32'h0);
    check_reg("rst_stat", 2'b11, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_reg("post_rst_stat", 2'b11, 32'h0);
    check_reg("post_rst_dx",   2'b01, 32'h0);

    // Debounced right press turns RIGHT into DOWN at the next tick.
    bus_write(2'b01, 32'h0000_0001);
    check_reg("dx_write_stat", 2'b11, 32'h80);
    check_reg("dx_write_dx",   2'b01, 32'h1);
    wait_phase(0);
    rightButton = 1'b1;
    repeat (10) @(negedge CLK);
    check_reg("deb_push_stat", 2'b11, 32'h81);
    rightButton = 1'b0;
    wait_tick();
    check_reg("deb_tick_dy",   2'b10, 32'h1);
    check_reg("deb_tick_dx",   2'b01, 32'h0);
    check_reg("deb_tick_stat", 2'b11, 32'hA0);

    // A 3-cycle glitch is rejected when debouncing is built in.
    bus_write(2'b11, 32'h1);
    check_reg("pause_stat", 2'b11, 32'hB0);
    press(1'b0, 3);
`ifdef STEER_DEBOUNCE_EN
    check_reg("glitch_stat", 2'b11, 32'hB0);
`else
    check_reg("glitch_stat", 2'b11, 32'hB1);
`endif
    bus_write(2'b11, 32'h3);
    check_reg("flush_stat", 2'b11, 32'hB0);

    // Overflow: five paused left presses keep four entries and set overflow.
    bus_write(2'b01, 32'h0000_0001);
    check_reg("ovf_setup_stat", 2'b11, 32'h90);
    for (int i = 0; i < 5; i++) press(1'b0, 10);
    check_reg("ovf_stat", 2'b11, 32'h9C);
    bus_write(2'b11, 32'h4);
    check_reg("ovf_clear_stat", 2'b11, 32'h84);

    // Rotation: the four queued left turns walk UP, LEFT, DOWN, RIGHT.
    wait_tick();
    check_reg("rot1_dy",   2'b10, 32'hFFFF_FFFF);
    check_reg("rot1_stat", 2'b11, 32'hE3);
    wait_tick();
    check_reg("rot2_dx",   2'b01, 32'hFFFF_FFFF);
    check_reg("rot2_stat", 2'b11, 32'hC2);
    wait_tick();
    check_reg("rot3_dy",   2'b10, 32'h1);
    check_reg("rot3_stat", 2'b11, 32'hA1);
    wait_tick();
    check_reg("rot4_dx",   2'b01, 32'h1);
    check_reg("rot4_stat", 2'b11, 32'h80);

    // Unsupported axis value is ignored.
    bus_write(2'b01, 32'h0000_0005);
    check_reg("ignored_dx_stat", 2'b11, 32'h80);
    check_reg("op00_read",       2'b00, 32'h0);

    // Write/tick collision: the pop is suppressed.
    bus_write(2'b11, 32'h1);
    press(1'b1, 10);
    press(1'b1, 10);
    check_reg("coll_setup_stat", 2'b11, 32'h92);
    wait_phase(TICK - 3);
    bus_write(2'b11, 32'h0);
    wait_phase(TICK - 1);
    bus_write(2'b11, 32'h0);
    check_reg("coll_ctl_stat", 2'b11, 32'h82);
    wait_phase(TICK - 1);
    bus_write(2'b10, 32'hFFFF_FFFF);
    check_reg("coll_dy_stat", 2'b11, 32'hE0);
    check_reg("coll_dy_dy",   2'b10, 32'hFFFF_FFFF);
    check_reg("coll_dy_dx",   2'b01, 32'h0);

    // Reset mid-queue (count 3, dir LEFT) and mid-debounce.
    bus_write(2'b01, 32'hFFFF_FFFF);
    check_reg("rq_left_stat", 2'b11, 32'hC0);
    bus_write(2'b11, 32'h1);
    for (int i = 0; i < 3; i++) press(1'b1, 10);
    check_reg("rq_queue_stat", 2'b11, 32'hD3);
    rightButton = 1'b1;
    repeat (4) @(negedge CLK);
    #1 RST_N = 1'b0;
    rightButton = 1'b0;
    check_reg("rq_rst_stat", 2'b11, 32'h0);
    check_reg("rq_rst_dx",   2'b01, 32'h0);
    check_reg("rq_rst_dy",   2'b10, 32'h0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);
    check_reg("rq_idle_stat", 2'b11, 32'h0);

    // New press after reset: queued, then discarded at the tick (valid=0).
    wait_phase(0);
    leftButton = 1'b1;
    repeat (10) @(negedge CLK);
    check_reg("rq_press_stat", 2'b11, 32'h01);
    leftButton = 1'b0;
    wait_tick();
    check_reg("rq_discard_stat", 2'b11, 32'h00);
    check_reg("rq_discard_dx",   2'b01, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
